wbm2axi_bridge: RTL and testbench
=================================

WBM2AXI_BRIDGE -- requirements
Module: wbm2axi_bridge

Interface
REQ-001 Parameter C_AXI_ADDR_WIDTH, default 28: AXI byte-address width.
REQ-002 Parameter C_AXI_DATA_WIDTH, default 128: AXI data width; power of two, >= DW.
REQ-003 Parameter C_AXI_ID_WIDTH, default 6: AXI ID width; every request uses ID 0.
REQ-004 Parameter DW, default 32: Wishbone data width; power of two, 8..C_AXI_DATA_WIDTH.
REQ-005 Parameter LGFIFO, default 5: log2 of maximum outstanding transactions.
REQ-006 Localparam AW = C_AXI_ADDR_WIDTH - log2(DW/8): Wishbone word-address width.
REQ-007 i_clk  in  1  sole clock; all logic on rising edge.
REQ-008 i_reset  in  1  synchronous, active-high reset.
REQ-009 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  pipelined Wishbone B4 request.
REQ-010 i_wb_addr  in  AW; i_wb_data  in  DW; i_wb_sel  in  DW/8.
REQ-011 o_wb_stall, o_wb_ack, o_wb_err  out  1 each; o_wb_data  out  DW.
REQ-012 AXI4 master ports: o_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}, i_axi_awready; o_axi_w{data,strb,last,valid}, i_axi_wready; i_axi_b{id,resp,valid}, o_axi_bready; o_axi_ar{...same as AW}, i_axi_arready; i_axi_r{id,data,resp,last,valid}, o_axi_rready.

Function
REQ-013 Constants: len=0, size=log2(C_AXI_DATA_WIDTH/8), burst=INCR(01), lock=0, cache=0011, prot=000, qos=0, wlast=1.
REQ-014 Request accepted when i_wb_stb && !o_wb_stall; accepted write drives awvalid and wvalid high next cycle; accepted read drives arvalid high next cycle.
REQ-015 awaddr/araddr = {i_wb_addr, log2(DW/8) zero bits}, registered at acceptance.
REQ-016 Lane = low log2(C_AXI_DATA_WIDTH/DW) bits of i_wb_addr; wdata = i_wb_data replicated across all lanes; wstrb = i_wb_sel in selected lane, zero elsewhere.
REQ-017 awvalid and wvalid clear independently, each on its own ready; each valid and its payload hold stable until its handshake.
REQ-018 o_wb_stall = 1 when: any of awvalid/wvalid/arvalid pending without ready this cycle, outstanding count = 2^LGFIFO, draining (REQ-023), or direction mismatch (REQ-019).
REQ-019 Direction mismatch: outstanding count nonzero and i_wb_we differs from direction of outstanding requests; reads and writes never overlap, so responses return in request order.
REQ-020 Read lane FIFO, depth 2^LGFIFO: pushed with lane at read acceptance, popped on rvalid; o_wb_data = selected DW slice of rdata, registered.
REQ-021 o_axi_bready = o_axi_rready = 1 always; o_wb_ack = 1 cycle after bvalid or rvalid when resp[1]=0 and not draining; o_wb_err instead when resp[1]=1; ack and err never both high.
REQ-022 Outstanding counter +1 on accept, -1 on bvalid/rvalid; simultaneous accept and response leaves it unchanged; never wraps.
REQ-023 i_wb_cyc low while count nonzero enters DRAIN: no acks/errs, stall high, until count reaches 0 and no AXI valid pending, then IDLE.
REQ-024 States: IDLE (count 0), BUSY_RD, BUSY_WR, DRAIN; IDLE->BUSY_x on accept; BUSY_x->IDLE when count reaches 0; BUSY_x->DRAIN on cyc low.
REQ-025 Response arriving with count 0 (protocol violation) ignored; counter stays 0.

Reset
REQ-026 On i_reset: all AXI valids 0, o_wb_ack 0, o_wb_err 0, o_wb_data 0, counter 0, lane FIFO empty, state IDLE; o_wb_stall 0 first cycle after reset.
REQ-027 Reset mid-transaction discards outstanding state; late AXI responses handled per REQ-025.

Verification
REQ-028 DW=32, AXI=128: write addr 0x3, data 0xDEADBEEF, sel 0xF -> awaddr 0xC, wstrb 0xF000, wdata 0xDEADBEEF x4; one ack after bvalid.
REQ-029 Four reads addr 0..3, rdata 0x44443333222211110000... lanes -> o_wb_data 0x11110000.., in order, four acks, no stall with ready=1.
REQ-030 Read outstanding, write requested -> stall until read response, then write accepted next cycle.
REQ-031 LGFIFO=2, arready=1, rvalid held low -> fifth read stalls; one rvalid -> fifth accepted same cycle count decrements.
REQ-032 bresp=2'b10 -> o_wb_err=1, o_wb_ack=0 that cycle.
REQ-033 cyc dropped with 3 reads outstanding -> no acks for those 3, stall high until last rvalid, then IDLE; i_reset mid-burst -> all outputs per REQ-026 next cycle.

Source files
------------

// File: rtl/wbm2axi_bridge.sv
// Pipelined Wishbone B4 master to AXI4 master bridge: one single-beat AXI transaction per Wishbone request.
// Reads and writes are never in flight together, so responses return in order; dropping cyc drains without acks.
module wbm2axi_bridge #(
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int C_AXI_DATA_WIDTH = 128,
  parameter int C_AXI_ID_WIDTH   = 6,
  parameter int DW               = 32,
  parameter int LGFIFO           = 5,
  localparam int AW              = C_AXI_ADDR_WIDTH - $clog2(DW/8)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_wb_cyc,
  input  logic                          i_wb_stb,
  input  logic                          i_wb_we,
  input  logic [AW-1:0]                 i_wb_addr,
  input  logic [DW-1:0]                 i_wb_data,
  input  logic [DW/8-1:0]               i_wb_sel,
  output logic                          o_wb_stall,
  output logic                          o_wb_ack,
  output logic                          o_wb_err,
  output logic [DW-1:0]                 o_wb_data,
  output logic [C_AXI_ID_WIDTH-1:0]     o_axi_awid,
  output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_awaddr,
  output logic [7:0]                    o_axi_awlen,
  output logic [2:0]                    o_axi_awsize,
  output logic [1:0]                    o_axi_awburst,
  output logic                          o_axi_awlock,
  output logic [3:0]                    o_axi_awcache,
  output logic [2:0]                    o_axi_awprot,
  output logic [3:0]                    o_axi_awqos,
  output logic                          o_axi_awvalid,
  input  logic                          i_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] o_axi_wstrb,
  output logic                          o_axi_wlast,
  output logic                          o_axi_wvalid,
  input  logic                          i_axi_wready,
  input  logic [C_AXI_ID_WIDTH-1:0]     i_axi_bid,
  input  logic [1:0]                    i_axi_bresp,
  input  logic                          i_axi_bvalid,
  output logic                          o_axi_bready,
  output logic [C_AXI_ID_WIDTH-1:0]     o_axi_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_araddr,
  output logic [7:0]                    o_axi_arlen,
  output logic [2:0]                    o_axi_arsize,
  output logic [1:0]                    o_axi_arburst,
  output logic                          o_axi_arlock,
  output logic [3:0]                    o_axi_arcache,
  output logic [2:0]                    o_axi_arprot,
  output logic [3:0]                    o_axi_arqos,
  output logic                          o_axi_arvalid,
  input  logic                          i_axi_arready,
  input  logic [C_AXI_ID_WIDTH-1:0]     i_axi_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_rdata,
  input  logic [1:0]                    i_axi_rresp,
  input  logic                          i_axi_rlast,
  input  logic                          i_axi_rvalid,
  output logic                          o_axi_rready
);

  localparam int AXILSB = $clog2(C_AXI_DATA_WIDTH/8);
  localparam int DWLSB  = $clog2(DW/8);
  localparam int LANEW  = $clog2(C_AXI_DATA_WIDTH/DW);
  localparam int LW     = (LANEW > 0) ? LANEW : 1;
  localparam int NLANE  = C_AXI_DATA_WIDTH / DW;
  localparam int DEPTH  = 1 << LGFIFO;
  localparam logic [LGFIFO:0] MAX_CNT = (LGFIFO+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR, DRAIN} state_t;

  state_t                     state;
  logic [LGFIFO:0]            cnt, cnt_nxt;
  logic                       dir_wr;
  logic [LW-1:0]              lane_mem [DEPTH];
  logic [LGFIFO-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]              req_lane, rsp_lane;
  logic [C_AXI_DATA_WIDTH/8-1:0] req_strb;
  logic                       accept, resp_b, resp_r, resp, resp_err;

  assign o_axi_awid    = '0;
  assign o_axi_awlen   = 8'd0;
  assign o_axi_awsize  = 3'(AXILSB);
  assign o_axi_awburst = 2'b01;
  assign o_axi_awlock  = 1'b0;
  assign o_axi_awcache = 4'b0011;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_awqos   = 4'd0;
  assign o_axi_arid    = '0;
  assign o_axi_arlen   = 8'd0;
  assign o_axi_arsize  = 3'(AXILSB);
  assign o_axi_arburst = 2'b01;
  assign o_axi_arlock  = 1'b0;
  assign o_axi_arcache = 4'b0011;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_arqos   = 4'd0;
  assign o_axi_wlast   = 1'b1;
  assign o_axi_bready  = 1'b1;
  assign o_axi_rready  = 1'b1;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, i_axi_bid, i_axi_rid, i_axi_rlast, i_axi_bresp[0], i_axi_rresp[0]};

  assign req_lane = (LANEW > 0) ? i_wb_addr[LW-1:0] : '0;
  assign rsp_lane = lane_mem[rd_ptr];

  // Responses only count against transactions of the current direction; strays are dropped.
  assign resp_b   = i_axi_bvalid && (cnt != '0) && dir_wr;
  assign resp_r   = i_axi_rvalid && (cnt != '0) && !dir_wr;
  assign resp     = resp_b || resp_r;
  assign resp_err = resp_b ? i_axi_bresp[1] : i_axi_rresp[1];

  // A full window may still accept when a response frees a slot in the same cycle.
  assign o_wb_stall = (o_axi_awvalid && !i_axi_awready)
                   || (o_axi_wvalid  && !i_axi_wready)
                   || (o_axi_arvalid && !i_axi_arready)
                   || ((cnt == MAX_CNT) && !resp)
                   || (state == DRAIN)
                   || ((cnt != '0) && (i_wb_we != dir_wr));

  assign accept = i_wb_stb && i_wb_cyc && !o_wb_stall;

  always_comb begin
    req_strb = '0;
    req_strb[int'(req_lane)*(DW/8) +: DW/8] = i_wb_sel;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (accept && !resp)
      cnt_nxt = cnt + 1'b1;
    else if (!accept && resp)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (accept && !i_wb_we)
      lane_mem[wr_ptr] <= req_lane;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dir_wr        <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_axi_awvalid <= 1'b0;
      o_axi_wvalid  <= 1'b0;
      o_axi_arvalid <= 1'b0;
      o_wb_ack      <= 1'b0;
      o_wb_err      <= 1'b0;
      o_wb_data     <= '0;
    end else begin
      o_wb_ack <= resp && !resp_err && i_wb_cyc && (state != DRAIN);
      o_wb_err <= resp &&  resp_err && i_wb_cyc && (state != DRAIN);
      cnt      <= cnt_nxt;

      if (i_axi_awready) o_axi_awvalid <= 1'b0;
      if (i_axi_wready)  o_axi_wvalid  <= 1'b0;
      if (i_axi_arready) o_axi_arvalid <= 1'b0;

      if (accept) begin
        dir_wr <= i_wb_we;
        if (i_wb_we) begin
          o_axi_awvalid <= 1'b1;
          o_axi_wvalid  <= 1'b1;
          o_axi_awaddr  <= C_AXI_ADDR_WIDTH'(i_wb_addr) << DWLSB;
          o_axi_wdata   <= {NLANE{i_wb_data}};
          o_axi_wstrb   <= req_strb;
        end else begin
          o_axi_arvalid <= 1'b1;
          o_axi_araddr  <= C_AXI_ADDR_WIDTH'(i_wb_addr) << DWLSB;
          wr_ptr        <= wr_ptr + 1'b1;
        end
      end

      if (resp_r) begin
        o_wb_data <= i_axi_rdata[int'(rsp_lane)*DW +: DW];
        rd_ptr    <= rd_ptr + 1'b1;
      end

      case (state)
        IDLE:
          if (accept) state <= i_wb_we ? BUSY_WR : BUSY_RD;
        BUSY_RD, BUSY_WR:
          if (cnt_nxt == '0)   state <= IDLE;
          else if (!i_wb_cyc)  state <= DRAIN;
        DRAIN:
          if ((cnt == '0) && !o_axi_awvalid && !o_axi_wvalid && !o_axi_arvalid)
            state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbm2axi_bridge.sv
// Directed bench for wbm2axi_bridge (DW=32, AXI data 128, window of 4 outstanding).
module tb_wbm2axi_bridge;

  localparam int AXW = 28;
  localparam int ADW = 128;
  localparam int IDW = 6;
  localparam int DW  = 32;
  localparam int AW  = AXW - 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_cyc, wb_stb, wb_we;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic [3:0]      wb_sel;
  logic            wb_stall, wb_ack, wb_err;
  logic [DW-1:0]   wb_rdata;
  logic [IDW-1:0]  awid, arid;
  logic [AXW-1:0]  awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize, awprot, arprot;
  logic [1:0]      awburst, arburst;
  logic            awlock, arlock;
  logic [3:0]      awcache, arcache, awqos, arqos;
  logic            awvalid, awready, wvalid, wready, wlast;
  logic [ADW-1:0]  wdata;
  logic [15:0]     wstrb;
  logic [IDW-1:0]  bid, rid;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready, arvalid, arready, rlast, rvalid, rready;
  logic [ADW-1:0]  rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wbm2axi_bridge #(
    .C_AXI_ADDR_WIDTH(AXW), .C_AXI_DATA_WIDTH(ADW), .C_AXI_ID_WIDTH(IDW),
    .DW(DW), .LGFIFO(2)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_sel(wb_sel),
    .o_wb_stall(wb_stall), .o_wb_ack(wb_ack), .o_wb_err(wb_err), .o_wb_data(wb_rdata),
    .o_axi_awid(awid), .o_axi_awaddr(awaddr), .o_axi_awlen(awlen), .o_axi_awsize(awsize),
    .o_axi_awburst(awburst), .o_axi_awlock(awlock), .o_axi_awcache(awcache),
    .o_axi_awprot(awprot), .o_axi_awqos(awqos), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wlast(wlast), .o_axi_wvalid(wvalid),
    .i_axi_wready(wready),
    .i_axi_bid(bid), .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(bready),
    .o_axi_arid(arid), .o_axi_araddr(araddr), .o_axi_arlen(arlen), .o_axi_arsize(arsize),
    .o_axi_arburst(arburst), .o_axi_arlock(arlock), .o_axi_arcache(arcache),
    .o_axi_arprot(arprot), .o_axi_arqos(arqos), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .i_axi_rid(rid), .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rlast(rlast),
    .i_axi_rvalid(rvalid), .o_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [ADW-1:0] obs, input logic [ADW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] lane_val [4];

  initial begin
    lane_val[0] = 32'h1111_0000;
    lane_val[1] = 32'h3333_2222;
    lane_val[2] = 32'h5555_4444;
    lane_val[3] = 32'h7777_6666;

    reset = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_addr = '0; wb_data = '0; wb_sel = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bid = '0; rid = '0; bresp = 2'b00; rresp = 2'b00; bvalid = 1'b0;
    rvalid = 1'b0; rlast = 1'b1;
    rdata = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

    step(); step();
    reset = 1'b0;
    settle();
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid",  wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_ack",     wb_ack, 0);
    chk("rst_err",     wb_err, 0);
    chk("rst_data",    wb_rdata, 0);
    chk("rst_stall",   wb_stall, 0);
    chk("ready_const", {bready, rready, wlast}, 3'b111);

    // single write, AW and W handshakes on different cycles
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_addr = 26'h3; wb_data = 32'hDEAD_BEEF; wb_sel = 4'hF;
    settle();
    chk("wr_stall0", wb_stall, 0);
    step();
    wb_stb = 1'b0;
    settle();
    chk("wr_awvalid", awvalid, 1);
    chk("wr_wvalid",  wvalid, 1);
    chk("wr_awaddr",  awaddr, 28'hC);
    chk("wr_wstrb",   wstrb, 16'hF000);
    chk("wr_wdata",   wdata, {4{32'hDEAD_BEEF}});
    chk("wr_consts",  {awlen, awsize, awburst, awlock, awcache, awprot, awqos},
                      {8'd0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0});
    chk("wr_ids",     {awid, arid}, 0);
    chk("wr_stall_pend", wb_stall, 1);
    awready = 1'b1;
    step();
    chk("wr_aw_done", awvalid, 0);
    chk("wr_w_hold",  wvalid, 1);
    chk("wr_w_hold_data", wdata, {4{32'hDEAD_BEEF}});
    wready = 1'b1;
    step();
    chk("wr_w_done", wvalid, 0);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    settle();
    chk("wr_ack", wb_ack, 1);
    chk("wr_noerr", wb_err, 0);
    step();
    chk("wr_ack_once", wb_ack, 0);

    // four back-to-back reads, one per lane
    arready = 1'b1;
    wb_stb = 1'b1; wb_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_addr = 26'(i);
      settle();
      chk("rd4_stall", wb_stall, 0);
      step();
      chk("rd4_araddr", araddr, 28'(4*i));
    end
    wb_stb = 1'b0;
    settle();
    chk("rd4_arvalid", arvalid, 1);
    rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) rvalid = 1'b0;
      settle();
      chk("rd4_ack",  wb_ack, 1);
      chk("rd4_data", wb_rdata, lane_val[i]);
    end
    step();
    chk("rd4_ack_end", wb_ack, 0);

    // write behind an outstanding read must wait for the read response
    wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 26'h5;
    step();
    wb_we = 1'b1; wb_addr = 26'h6; wb_data = 32'hCAFE_F00D; wb_sel = 4'h3;
    settle();
    chk("mix_stall_a", wb_stall, 1);
    step();
    chk("mix_stall_b", wb_stall, 1);
    rvalid = 1'b1;
    settle();
    chk("mix_stall_c", wb_stall, 1);
    step();
    rvalid = 1'b0;
    settle();
    chk("mix_rd_ack",  wb_ack, 1);
    chk("mix_rd_data", wb_rdata, 32'h3333_2222);
    chk("mix_stall_free", wb_stall, 0);
    step();
    wb_stb = 1'b0;
    settle();
    chk("mix_awvalid", awvalid, 1);
    chk("mix_awaddr",  awaddr, 28'h18);
    chk("mix_wstrb",   wstrb, 16'h0300);
    chk("mix_wdata",   wdata, {4{32'hCAFE_F00D}});
    step();
    bvalid = 1'b1; bresp = 2'b10;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    settle();
    chk("berr_err", wb_err, 1);
    chk("berr_ack", wb_ack, 0);
    step();
    chk("berr_once", wb_err, 0);

    // window of 4: fifth read waits, then rides along with a response
    wb_stb = 1'b1; wb_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_addr = 26'(i);
      settle();
      chk("full_issue_stall", wb_stall, 0);
      step();
    end
    wb_addr = 26'h7;
    settle();
    chk("full_stall_a", wb_stall, 1);
    step();
    chk("full_stall_b", wb_stall, 1);
    chk("full_no_ar", arvalid, 0);
    rvalid = 1'b1;
    settle();
    chk("full_stall_rel", wb_stall, 0);
    step();
    wb_stb = 1'b0; rvalid = 1'b0;
    settle();
    chk("full_ack0",    wb_ack, 1);
    chk("full_data0",   wb_rdata, lane_val[0]);
    chk("full_arvalid", arvalid, 1);
    chk("full_araddr",  araddr, 28'h1C);
    chk("full_cnt_kept", wb_stall, 1);
    step();
    rvalid = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      if (i == 4) rvalid = 1'b0;
      settle();
      chk("full_ack",  wb_ack, 1);
      chk("full_data", wb_rdata, lane_val[(i == 4) ? 3 : i]);
    end
    step();
    chk("full_idle_stall", wb_stall, 0);

    // cyc dropped with three reads in flight: drain silently
    wb_stb = 1'b1; wb_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_addr = 26'(i);
      step();
    end
    wb_stb = 1'b0; wb_cyc = 1'b0;
    step();
    chk("drain_stall", wb_stall, 1);
    rvalid = 1'b1;
    step();
    chk("drain_ack1", wb_ack, 0);
    chk("drain_stall1", wb_stall, 1);
    step();
    chk("drain_ack2", wb_ack, 0);
    chk("drain_stall2", wb_stall, 1);
    step();
    rvalid = 1'b0;
    settle();
    chk("drain_ack3", wb_ack, 0);
    chk("drain_stall3", wb_stall, 1);
    step();
    chk("drain_idle", wb_stall, 0);

    // reset with a write pending on AW/W
    awready = 1'b0; wready = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 26'h1;
    wb_data = 32'h0000_0001; wb_sel = 4'hF;
    step();
    wb_stb = 1'b0;
    settle();
    chk("mid_awvalid", awvalid, 1);
    chk("mid_data_before", wb_rdata, lane_val[2]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid",  wvalid, 0);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_ackerr",  {wb_ack, wb_err}, 2'b00);
    chk("mid_rst_data",    wb_rdata, 0);
    chk("mid_rst_stall",   wb_stall, 0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    settle();
    chk("late_b_ack", wb_ack, 0);
    chk("late_b_err", wb_err, 0);
    arready = 1'b1;
    wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 26'h2;
    settle();
    chk("late_b_cnt0", wb_stall, 0);
    step();
    wb_stb = 1'b0;
    settle();
    chk("post_rst_arvalid", arvalid, 1);
    chk("post_rst_araddr",  araddr, 28'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
